// File: rtl/count_checker_if.sv
// Observed counter bus: sampled value plus its qualifying valid.
// The producer side drives it and the checker side only samples it.
interface count_checker_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic [WIDTH-1:0] count_in;
    logic             count_valid;

    modport master (
        output count_in,
        output count_valid
    );

    modport slave (
        input count_in,
        input count_valid
    );
endinterface

// File: rtl/count_checker.sv
// Watches a free-running up-counter, locks onto its +1 sequence and flags skips,
// repeats and stalls through registered status flags and counters.
module count_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned LOCK_N      = 2,
    parameter int unsigned STALL_LIMIT = 8,
    parameter int unsigned ERR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    count_checker_if.slave    bus,
    output logic              locked,
    output logic              error,
    output logic              stall,
    output logic [ERR_W-1:0]  err_count,
    output logic [ERR_W-1:0]  wrap_count
);

    localparam logic [3:0] LockN      = 4'(LOCK_N);
    localparam logic [7:0] StallLimit = 8'(STALL_LIMIT);

    typedef enum logic [1:0] {
        StUnlocked,
        StAcquire,
        StLocked
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   expected_q, expected_d;
    logic [3:0]         match_cnt_q, match_cnt_d;
    logic [7:0]         idle_cnt_q, idle_cnt_d;
    logic               error_q, error_d;
    logic               stall_q, stall_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [ERR_W-1:0]   wrap_count_q, wrap_count_d;

    logic [WIDTH-1:0]   next_of_sample;
    logic               hit;

    assign next_of_sample = bus.count_in + WIDTH'(1);
    assign hit            = (bus.count_in == expected_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StUnlocked;
            expected_q   <= '0;
            match_cnt_q  <= '0;
            idle_cnt_q   <= '0;
            error_q      <= 1'b0;
            stall_q      <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            match_cnt_q  <= match_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            error_q      <= error_d;
            stall_q      <= stall_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        match_cnt_d  = match_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        error_d      = 1'b0;
        stall_d      = stall_q;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;

        case (state_q)
            StUnlocked: begin
                if (bus.count_valid) begin
                    expected_d  = next_of_sample;
                    match_cnt_d = '0;
                    state_d     = StAcquire;
                end
            end
            StAcquire: begin
                if (bus.count_valid) begin
                    if (hit) begin
                        expected_d  = expected_q + WIDTH'(1);
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_q + 4'd1 == LockN) begin
                            state_d = StLocked;
                            stall_d = 1'b0;
                        end
                    end else begin
                        // Resynchronise silently; errors only count once locked.
                        expected_d  = next_of_sample;
                        match_cnt_d = '0;
                    end
                end
            end
            StLocked: begin
                if (bus.count_valid) begin
                    idle_cnt_d = '0;
                    if (hit) begin
                        expected_d = expected_q + WIDTH'(1);
                        if (bus.count_in == '0) begin
                            wrap_count_d = wrap_count_q + ERR_W'(1);
                        end
                    end else begin
                        error_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        expected_d  = next_of_sample;
                        match_cnt_d = '0;
                        state_d     = StAcquire;
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                    if (idle_cnt_q + 8'd1 == StallLimit) begin
                        stall_d    = 1'b1;
                        idle_cnt_d = '0;
                        state_d    = StUnlocked;
                    end
                end
            end
            default: state_d = StUnlocked;
        endcase
    end

    assign locked     = (state_q == StLocked);
    assign error      = error_q;
    assign stall      = stall_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_count_checker.sv
// Directed plus randomized bench for count_checker; a wide-counter and a
// 2-bit-counter instance share one bus and are both checked against a sequence model.
module tb_count_checker;

    localparam int unsigned WIDTH       = 4;
    localparam int unsigned LOCK_N      = 2;
    localparam int unsigned STALL_LIMIT = 8;
    localparam int          MOD         = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    count_checker_if #(.WIDTH(WIDTH)) bus ();

    logic       locked_a, error_a, stall_a;
    logic [7:0] err_a, wrap_a;
    logic       locked_s, error_s, stall_s;
    logic [1:0] err_s, wrap_s;

    count_checker #(
        .WIDTH(WIDTH), .LOCK_N(LOCK_N), .STALL_LIMIT(STALL_LIMIT), .ERR_W(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .locked(locked_a), .error(error_a), .stall(stall_a),
        .err_count(err_a), .wrap_count(wrap_a)
    );

    count_checker #(
        .WIDTH(WIDTH), .LOCK_N(LOCK_N), .STALL_LIMIT(STALL_LIMIT), .ERR_W(2)
    ) dut_sat (
        .clk(clk), .reset(reset), .bus(bus),
        .locked(locked_s), .error(error_s), .stall(stall_s),
        .err_count(err_s), .wrap_count(wrap_s)
    );

    int n_vec = 0;
    int n_err = 0;

    // Sequence model: last sample, length of the current run of +1 steps, idle gap.
    int m_have, m_last, m_run, m_gap;
    int m_locked, m_error, m_stall;
    int m_err8, m_err2, m_wrap8, m_wrap2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic rst_n, input logic v, input int val);
        m_error = 0;
        if (!rst_n) begin
            m_have = 0; m_last = 0; m_run = 0; m_gap = 0;
            m_locked = 0; m_stall = 0;
            m_err8 = 0; m_err2 = 0; m_wrap8 = 0; m_wrap2 = 0;
        end else if (v) begin
            m_gap = 0;
            if (m_have == 0) begin
                m_have = 1;
                m_run  = 0;
            end else if (val == (m_last + 1) % MOD) begin
                if (m_locked != 0) begin
                    if (val == 0) begin
                        m_wrap8 = (m_wrap8 + 1) % 256;
                        m_wrap2 = (m_wrap2 + 1) % 4;
                    end
                end else begin
                    m_run++;
                    if (m_run == LOCK_N) begin
                        m_locked = 1;
                        m_stall  = 0;
                    end
                end
            end else begin
                if (m_locked != 0) begin
                    m_error  = 1;
                    m_err8   = (m_err8 < 255) ? m_err8 + 1 : 255;
                    m_err2   = (m_err2 < 3) ? m_err2 + 1 : 3;
                    m_locked = 0;
                end
                m_run = 0;
            end
            m_last = val;
        end else if (m_locked != 0) begin
            m_gap++;
            if (m_gap == STALL_LIMIT) begin
                m_stall  = 1;
                m_locked = 0;
                m_have   = 0;
                m_gap    = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("locked",      32'(locked_a), 32'(m_locked));
        chk("error",       32'(error_a),  32'(m_error));
        chk("stall",       32'(stall_a),  32'(m_stall));
        chk("err_count",   32'(err_a),    32'(m_err8));
        chk("wrap_count",  32'(wrap_a),   32'(m_wrap8));
        chk("sat_locked",  32'(locked_s), 32'(m_locked));
        chk("sat_err",     32'(err_s),    32'(m_err2));
        chk("sat_wrap",    32'(wrap_s),   32'(m_wrap2));
    endtask

    task automatic step(input logic rst_n, input logic v, input int val);
        reset           = rst_n;
        bus.count_valid = v;
        bus.count_in    = 4'(val);
        @(posedge clk);
        model(rst_n, v, val);
        #1;
        check_all();
    endtask

    function automatic int nxt();
        return (m_last + 1) % MOD;
    endfunction

    initial begin
        int r;
        reset           = 1'b0;
        bus.count_valid = 1'b0;
        bus.count_in    = '0;

        // Reset for two cycles, then a clean run that locks after the third sample.
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        chk("reset_err", 32'(err_a), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, i);
        chk("lock_latency", 32'(locked_a), 32'd1);

        // Run through 15 -> 0 -> 1.
        for (int i = 3; i < 18; i++) step(1'b1, 1'b1, i % MOD);
        chk("wrap_once", 32'(wrap_a), 32'd1);

        // Skip: 2..5 then 7, re-lock on 8,9.
        for (int i = 2; i <= 5; i++) step(1'b1, 1'b1, i);
        step(1'b1, 1'b1, 7);
        chk("skip_err", 32'(err_a), 32'd1);
        step(1'b1, 1'b1, 8);
        step(1'b1, 1'b1, 9);
        chk("relock", 32'(locked_a), 32'd1);

        // Repeated values drive the 2-bit error counter into saturation.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, m_last);
            step(1'b1, 1'b1, nxt());
            step(1'b1, 1'b1, nxt());
        end
        chk("sat_hold", 32'(err_s), 32'd3);

        // Gap one short of the stall limit, then the full limit.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, nxt());
        chk("no_stall", 32'(stall_a), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0);
        chk("stall_set", 32'(stall_a), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, (i + 6) % MOD);
        chk("stall_clear", 32'(stall_a), 32'd0);

        // Reset coinciding with a mismatching sample.
        step(1'b0, 1'b1, m_last);
        chk("rst_no_error", 32'(error_a), 32'd0);
        step(1'b1, 1'b0, 0);

        // Randomized traffic: mostly clean counting with skips, repeats, gaps and resets.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 1) begin
                step(1'b0, 1'(r), 0);
            end else if (r < 4) begin
                r = int'($urandom_range(5, 10));
                for (int j = 0; j < r; j++) step(1'b1, 1'b0, 0);
            end else if (r < 15) begin
                step(1'b1, 1'b0, 0);
            end else if (r < 22) begin
                step(1'b1, 1'b1, int'($urandom_range(0, MOD - 1)));
            end else begin
                step(1'b1, 1'b1, nxt());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
